// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, stall encoding,
// load-op bit positions and hold-FSM state encoding.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 81;
  localparam int MEM_TO_WB_WD = 70;
  localparam int StallBus     = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int MEM_LW  = 0;
  localparam int MEM_LH  = 1;
  localparam int MEM_LHU = 2;
  localparam int MEM_LB  = 3;
  localparam int MEM_LBU = 4;

  typedef enum logic {
    FRESH = 1'b0,
    HELD  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extraction: picks the addressed byte/halfword, extends it, and
// flags misaligned word/halfword loads.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [4:0]  mem_op,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [31:0] result,
  output logic        adel
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by sign/zero extension by load type.
  always_comb begin
    case (offset)
      2'd0:    byte_s = data[7:0];
      2'd1:    byte_s = data[15:8];
      2'd2:    byte_s = data[23:16];
      2'd3:    byte_s = data[31:24];
      default: byte_s = data[7:0];
    endcase

    if (offset[1]) begin
      half_s = data[31:16];
    end else begin
      half_s = data[15:0];
    end

    if (mem_op[MEM_LW]) begin
      result = data;
    end else if (mem_op[MEM_LH]) begin
      result = {{16{half_s[15]}}, half_s};
    end else if (mem_op[MEM_LHU]) begin
      result = {16'h0000, half_s};
    end else if (mem_op[MEM_LB]) begin
      result = {{24{byte_s[7]}}, byte_s};
    end else if (mem_op[MEM_LBU]) begin
      result = {24'h000000, byte_s};
    end else begin
      result = data;
    end
  end

  assign adel = (mem_op[MEM_LW] && (offset != 2'd0)) ||
                ((mem_op[MEM_LH] || mem_op[MEM_LHU]) && offset[0]);

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, keeps SRAM load data
// alive across stalls, and drives write-back and forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id_fwd,
  output logic                    adel
);

  logic [EX_TO_MEM_WD-1:0] stage_r;
  hold_state_e             state_r;
  hold_state_e             state_s;
  logic [31:0]             hold_r;
  logic                    latch_s;
  logic                    stay_s;
  logic                    bubble_s;

  logic [4:0]  mem_op_s;
  logic [31:0] pc_s;
  logic        sel_rf_res_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic [31:0] ex_result_s;
  logic [31:0] eff_data_s;
  logic [31:0] load_data_s;
  logic [31:0] rf_wdata_s;
  logic        wb_we_s;
  logic        stall_unused_s;

  assign stay_s   = (stall[3] == Stop) && (stall[4] == Stop);
  assign bubble_s = (stall[3] == Stop) && (stall[4] == NoStop);

  // Stage register: flush and bubble both insert an all-zero instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_r <= {EX_TO_MEM_WD{1'b0}};
    end else if (flush) begin
      stage_r <= {EX_TO_MEM_WD{1'b0}};
    end else if (bubble_s) begin
      stage_r <= {EX_TO_MEM_WD{1'b0}};
    end else if (stall[3] == NoStop) begin
      stage_r <= ex_to_mem_bus;
    end else begin
      stage_r <= stage_r;
    end
  end

  // Hold FSM state register and captured load data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= FRESH;
      hold_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        hold_r <= data_sram_rdata;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  // Hold FSM next state: SRAM data is only trustworthy on the first stage cycle.
  always_comb begin
    state_s = state_r;
    latch_s = 1'b0;
    if (flush) begin
      state_s = FRESH;
    end else begin
      case (state_r)
        FRESH: begin
          if (stay_s) begin
            state_s = HELD;
            latch_s = 1'b1;
          end else begin
            state_s = FRESH;
          end
        end
        HELD: begin
          if (stay_s) begin
            state_s = HELD;
          end else begin
            state_s = FRESH;
          end
        end
        default: state_s = FRESH;
      endcase
    end
  end

  assign mem_op_s     = stage_r[80:76];
  assign pc_s         = stage_r[75:44];
  assign sel_rf_res_s = stage_r[38];
  assign rf_we_s      = stage_r[37];
  assign rf_waddr_s   = stage_r[36:32];
  assign ex_result_s  = stage_r[31:0];

  // SRAM enables are consumed upstream; unused stall bits belong to other stages.
  assign stall_unused_s = &{stage_r[43:39], stall[5], stall[2:0]};

  assign eff_data_s = (state_r == FRESH) ? data_sram_rdata : hold_r;

  load_ext u_load_ext (
    .mem_op (mem_op_s),
    .offset (ex_result_s[1:0]),
    .data   (eff_data_s),
    .result (load_data_s),
    .adel   (adel)
  );

  assign rf_wdata_s    = sel_rf_res_s ? load_data_s : ex_result_s;
  assign wb_we_s       = rf_we_s & ~adel;
  assign mem_to_wb_bus = {pc_s, wb_we_s, rf_waddr_s, rf_wdata_s};
  assign mem_to_id_fwd = {wb_we_s, rf_waddr_s, rf_wdata_s};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios then randomized traffic
// against a behavioural model of the stage contents and their load data.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic [5:0]  stall;
  logic [80:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_fwd;
  logic        adel;

  int errors = 0;
  int checks = 0;

  // Model: which instruction occupies the stage and whether its data is frozen.
  logic [80:0] m_inst;
  logic        m_fv;
  logic [31:0] m_frozen;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_fwd   (mem_to_id_fwd),
    .adel            (adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [80:0] mk(input logic [4:0] op, input logic [31:0] ex,
                                     input logic sel, input logic we,
                                     input logic [4:0] wa, input logic [31:0] pc);
    return {op, pc, (op != 5'd0), 4'h0, sel, we, wa, ex};
  endfunction

  function automatic logic model_adel(input logic [4:0] op, input int unsigned off);
    return (op == 5'b00001 && off != 0) || ((op == 5'b00010 || op == 5'b00100) && (off % 2) == 1);
  endfunction

  function automatic logic [31:0] model_load(input logic [4:0] op, input int unsigned off,
                                             input logic [31:0] d);
    int unsigned b;
    int unsigned h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      5'b00001: return d;
      5'b00010: return (h >= 32768) ? h - 65536 : h;
      5'b00100: return h;
      5'b01000: return (b >= 128) ? b - 256 : b;
      5'b10000: return b;
      default:  return d;
    endcase
  endfunction

  function automatic logic [69:0] exp_wb(input logic [80:0] inst, input logic [31:0] d);
    logic [4:0]  op;
    int unsigned off;
    logic [31:0] wd;
    logic        ad;
    op  = inst[80:76];
    off = inst[1:0];
    ad  = model_adel(op, off);
    wd  = inst[38] ? model_load(op, off, d) : inst[31:0];
    return {inst[75:44], inst[37] & ~ad, inst[36:32], wd};
  endfunction

  task automatic apply(input logic [5:0] st, input logic fl, input logic [80:0] bus,
                       input logic [31:0] rd);
    logic [31:0] ed;
    logic [69:0] ew;
    stall           = st;
    flush           = fl;
    ex_to_mem_bus   = bus;
    data_sram_rdata = rd;
    #1;
    ed = m_fv ? m_frozen : rd;
    ew = exp_wb(m_inst, ed);
    check_eq("wb_bus", mem_to_wb_bus, ew);
    check_eq("fwd_bus", {32'h0, mem_to_id_fwd}, {32'h0, ew[37:0]});
    check_eq("adel", {69'h0, adel}, {69'h0, model_adel(m_inst[80:76], m_inst[1:0])});
  endtask

  task automatic clock_edge();
    if (flush) begin
      m_inst = 81'h0;
      m_fv   = 1'b0;
    end else if (stall[3] && !stall[4]) begin
      m_inst = 81'h0;
      m_fv   = 1'b0;
    end else if (!stall[3]) begin
      m_inst = ex_to_mem_bus;
      m_fv   = 1'b0;
    end else if (!m_fv) begin
      m_frozen = data_sram_rdata;
      m_fv     = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] RUN    = 6'b000000;
  localparam logic [5:0] HOLD   = 6'b011000;
  localparam logic [5:0] BUBBLE = 6'b001000;

  initial begin
    logic [80:0] nop;
    logic [4:0]  op;
    logic [5:0]  st;
    int          sel;
    nop = 81'h0;
    m_inst = 81'h0; m_fv = 1'b0; m_frozen = 32'h0;
    resetn = 1'b0; flush = 1'b0; stall = 6'h0;
    ex_to_mem_bus = mk(5'b00001, 32'h100, 1'b1, 1'b1, 5'd3, 32'h4000);
    data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    check_eq("reset_wb", mem_to_wb_bus, 70'h0);
    check_eq("reset_fwd", {32'h0, mem_to_id_fwd}, 70'h0);
    check_eq("reset_adel", {69'h0, adel}, 70'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // lb sign extension
    apply(RUN, 1'b0, mk(5'b01000, 32'h1003, 1'b1, 1'b1, 5'd5, 32'h1000), 32'h0);
    clock_edge();
    apply(RUN, 1'b0, mk(5'b10000, 32'h2001, 1'b1, 1'b1, 5'd6, 32'h1004), 32'h80FF_1234);
    check_eq("lb_data", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'hFFFF_FF80});
    check_eq("lb_we", {69'h0, mem_to_wb_bus[37]}, 70'h1);
    clock_edge();
    // lbu and lhu zero extension
    apply(RUN, 1'b0, mk(5'b00100, 32'h3002, 1'b1, 1'b1, 5'd7, 32'h1008), 32'h0000_AB00);
    check_eq("lbu_data", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'h0000_00AB});
    clock_edge();
    apply(RUN, 1'b0, mk(5'b00001, 32'h4000, 1'b1, 1'b1, 5'd8, 32'h100C), 32'h8001_0000);
    check_eq("lhu_data", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'h0000_8001});
    clock_edge();
    // lw held across a three-cycle stall
    apply(HOLD, 1'b0, mk(5'b00001, 32'h5000, 1'b1, 1'b1, 5'd9, 32'h1010), 32'hDEAD_BEEF);
    check_eq("held_first", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'hDEAD_BEEF});
    clock_edge();
    for (int i = 0; i < 2; i++) begin
      apply(HOLD, 1'b0, mk(5'b00001, 32'h5000, 1'b1, 1'b1, 5'd9, 32'h1010), 32'h1111_1111);
      check_eq("held_stall", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'hDEAD_BEEF});
      clock_edge();
    end
    apply(RUN, 1'b0, mk(5'b00001, 32'h5000, 1'b1, 1'b1, 5'd9, 32'h1010), 32'h1111_1111);
    check_eq("held_release", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'hDEAD_BEEF});
    clock_edge();
    apply(RUN, 1'b0, mk(5'b00001, 32'h6002, 1'b1, 1'b1, 5'd10, 32'h1014), 32'h2222_3333);
    check_eq("after_hold_live", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'h2222_3333});
    clock_edge();
    // misaligned loads: lw off 2 is in stage now; then lh off 1, lh off 2
    apply(RUN, 1'b0, mk(5'b00010, 32'h6001, 1'b1, 1'b1, 5'd11, 32'h1018), 32'h1234_5678);
    check_eq("lw_adel", {69'h0, adel}, 70'h1);
    check_eq("lw_adel_we", {69'h0, mem_to_wb_bus[37]}, 70'h0);
    clock_edge();
    apply(RUN, 1'b0, mk(5'b00010, 32'h6002, 1'b1, 1'b1, 5'd12, 32'h101C), 32'h1234_5678);
    check_eq("lh_off1_adel", {69'h0, adel}, 70'h1);
    clock_edge();
    apply(BUBBLE, 1'b0, mk(5'b00001, 32'h7000, 1'b1, 1'b1, 5'd13, 32'h1020), 32'h8765_4321);
    check_eq("lh_off2_adel", {69'h0, adel}, 70'h0);
    check_eq("lh_off2_data", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'hFFFF_8765});
    clock_edge();
    // bubble inserted by previous cycle
    apply(RUN, 1'b0, mk(5'b00001, 32'h7000, 1'b1, 1'b1, 5'd13, 32'h1020), 32'h5555_5555);
    check_eq("bubble_zero", mem_to_wb_bus, 70'h0);
    clock_edge();
    // flush while HELD
    apply(HOLD, 1'b0, nop, 32'hAAAA_0000);
    clock_edge();
    apply(HOLD, 1'b1, nop, 32'hBBBB_0000);
    check_eq("held_before_flush", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'hAAAA_0000});
    clock_edge();
    apply(RUN, 1'b0, mk(5'b00001, 32'h8000, 1'b1, 1'b1, 5'd14, 32'h1024), 32'hCCCC_0000);
    check_eq("flush_zero", mem_to_wb_bus, 70'h0);
    clock_edge();
    // async reset mid-HELD
    apply(HOLD, 1'b0, nop, 32'h0F0F_0F0F);
    clock_edge();
    apply(HOLD, 1'b0, nop, 32'hF0F0_F0F0);
    check_eq("pre_reset_held", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'h0F0F_0F0F});
    resetn = 1'b0;
    #1;
    m_inst = 81'h0; m_fv = 1'b0;
    check_eq("async_reset_wb", mem_to_wb_bus, 70'h0);
    check_eq("async_reset_fwd", {32'h0, mem_to_id_fwd}, 70'h0);
    resetn = 1'b1;
    #1;
    apply(RUN, 1'b0, nop, 32'h1357_9BDF);
    clock_edge();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 5);
      op  = (sel == 0) ? 5'd0 : 5'(1 << (sel - 1));
      st  = 6'($urandom);
      st[3] = ($urandom_range(0, 2) == 0);
      st[4] = ($urandom_range(0, 1) == 1);
      apply(st, ($urandom_range(0, 15) == 0),
            mk(op, $urandom, (op != 5'd0) ? 1'b1 : 1'($urandom), 1'($urandom),
               5'($urandom), $urandom),
            $urandom);
      clock_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
